// File: rtl/word_lane_serializer.sv
// Valid/ready word-to-lane serializer; lane order chosen per word (MSB- or LSB-first).
// Optional SPLITTER_ZERO_SKIP_EN drops all-zero lanes from the output stream.
module word_lane_serializer #(
    parameter int WORD_W = 32,
    parameter int LANE_W = 8,
    parameter int IDX_W  = $clog2(WORD_W / LANE_W)
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [WORD_W-1:0] in_data,
    input  logic              in_msb_first,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [LANE_W-1:0] out_data,
    output logic [IDX_W-1:0]  out_idx,
    output logic              out_last
);
    localparam int NLANES = WORD_W / LANE_W;
    localparam logic [IDX_W-1:0] TOP = IDX_W'(NLANES - 1);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t            state_q, state_d;
    logic [WORD_W-1:0] buf_q, buf_d;
    logic              msb_q, msb_d;
    logic [IDX_W-1:0]  ptr_q, ptr_d;

    logic [LANE_W-1:0] lane [NLANES];
    logic [IDX_W-1:0]  first_idx;
    logic [IDX_W-1:0]  next_idx;
    logic              last;
    logic              in_xfer;
    logic              out_xfer;

    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            lane[k] = buf_q[k*LANE_W +: LANE_W];
        end
    end

`ifdef SPLITTER_ZERO_SKIP_EN
    logic [NLANES-1:0] nz_in;
    logic [NLANES-1:0] nz_buf;

    always_comb begin
        for (int k = 0; k < NLANES; k++) begin
            nz_in[k]  = |in_data[k*LANE_W +: LANE_W];
            nz_buf[k] = |lane[k];
        end
    end

    // Scans run so the last hit wins; an all-zero word falls back to the final lane.
    always_comb begin
        first_idx = in_msb_first ? '0 : TOP;
        if (in_msb_first) begin
            for (int k = 0; k < NLANES; k++) begin
                if (nz_in[k]) first_idx = IDX_W'(k);
            end
        end else begin
            for (int k = NLANES - 1; k >= 0; k--) begin
                if (nz_in[k]) first_idx = IDX_W'(k);
            end
        end
    end

    always_comb begin
        next_idx = ptr_q;
        last     = 1'b1;
        if (msb_q) begin
            for (int k = 0; k < NLANES; k++) begin
                if (nz_buf[k] && k < int'(ptr_q)) begin
                    next_idx = IDX_W'(k);
                    last     = 1'b0;
                end
            end
        end else begin
            for (int k = NLANES - 1; k >= 0; k--) begin
                if (nz_buf[k] && k > int'(ptr_q)) begin
                    next_idx = IDX_W'(k);
                    last     = 1'b0;
                end
            end
        end
    end
`else
    assign first_idx = in_msb_first ? TOP : '0;
    assign next_idx  = msb_q ? ptr_q - IDX_W'(1) : ptr_q + IDX_W'(1);
    assign last      = msb_q ? (ptr_q == '0) : (ptr_q == TOP);
`endif

    assign out_valid = (state_q == EMIT);
    assign out_xfer  = out_valid && out_ready;
    assign in_ready  = reset_n && (state_q == IDLE || (out_xfer && last));
    assign in_xfer   = in_valid && in_ready;
    assign out_data  = out_valid ? lane[ptr_q] : '0;
    assign out_idx   = out_valid ? ptr_q : '0;
    assign out_last  = out_valid && last;

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        msb_d   = msb_q;
        ptr_d   = ptr_q;
        if (in_xfer) begin
            state_d = EMIT;
            buf_d   = in_data;
            msb_d   = in_msb_first;
            ptr_d   = first_idx;
        end else if (out_xfer) begin
            if (last) state_d = IDLE;
            else      ptr_d   = next_idx;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            buf_q   <= '0;
            msb_q   <= 1'b0;
            ptr_q   <= '0;
        end else begin
            state_q <= state_d;
            buf_q   <= buf_d;
            msb_q   <= msb_d;
            ptr_q   <= ptr_d;
        end
    end
endmodule

// File: doc/word_lane_serializer.md
# word_lane_serializer

Parametrised, handshaked word splitter: accepts one WORD_W-bit word on a valid/ready input port and emits it as WORD_W/LANE_W consecutive LANE_W-bit lanes on a valid/ready output port, in a per-word selectable order (most-significant lane first or least-significant lane first). It is the sequential successor of the fixed 32-to-4×8 combinational splitter. It sits between a word-wide producer (register file or memory read path) and a narrow byte/lane consumer, and provides full back-pressure in both directions.

## Interface
Parameters:
- WORD_W, 32, input word width; must be an integer multiple of LANE_W.
- LANE_W, 8, output lane width; NLANES = WORD_W/LANE_W ≥ 2.
- IDX_W, $clog2(NLANES), lane index width.

Ports (one clock; reset is asynchronous and active-low):
- clk  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block accepts in_data this cycle.
- in_data  input  WORD_W  word to split; lane k = in_data[k*LANE_W +: LANE_W].
- in_msb_first  input  1  sampled with the word: 1 = lanes NLANES-1 down to 0, 0 = lanes 0 up to NLANES-1.
- out_valid  output  1  out_data holds a lane.
- out_ready  input  1  consumer takes the lane this cycle.
- out_data  output  LANE_W  current lane value; 0 when out_valid=0.
- out_idx  output  IDX_W  lane number k of out_data; 0 when out_valid=0.
- out_last  output  1  final lane of the current word; 0 when out_valid=0.

## Operation
- State: IDLE or EMIT. Internal registers: word buffer (WORD_W), mode bit, lane pointer (IDX_W).
- Input transfer when in_valid && in_ready; output transfer when out_valid && out_ready.
- in_ready = reset_n && (state==IDLE || (out_valid && out_ready && out_last)).
- IDLE: out_valid=0. On input transfer, capture in_data and in_msb_first, set the pointer to the first lane in order, go to EMIT.
- EMIT: out_valid=1; out_data/out_idx come from the buffer at the pointer.
  - On an output transfer with out_last=0: advance the pointer to the next lane in order.
  - On an output transfer with out_last=1 and a simultaneous input transfer: load the new word and stay in EMIT, with no bubble.
  - On an output transfer with out_last=1 and no input: return to IDLE.
- No output transfer: all outputs hold their values.
- out_last=1 when the pointer is at lane 0 (MSB-first) or lane NLANES-1 (LSB-first), unless modified by the configuration below.
- in_data and in_msb_first are ignored outside input transfers. Changing in_msb_first mid-word has no effect.
- Reset (any time, including mid-word): the in-flight word is discarded; state=IDLE, pointer=0, buffer=0, out_valid=0, out_data=0, out_idx=0, out_last=0, in_ready=0 while reset_n=0, then 1 from the first cycle after release.

## Timing
- Latency: a word accepted at edge N produces its first lane with out_valid=1 in the cycle after edge N.
- Throughput: one lane per cycle with out_ready held high. Back-to-back words take NLANES cycles per word with no idle cycle.
- All outputs except in_ready are register-driven or a mux of registers. in_ready combinationally depends on out_ready.

## Configuration
- Macro: SPLITTER_ZERO_SKIP_EN.
- Defined:
  - Lanes whose value is 0 are not emitted; the pointer jumps to the next nonzero lane in order.
  - out_last marks the last nonzero lane in order.
  - An all-zero word emits exactly one lane, the final lane in order (lane 0 if MSB-first, lane NLANES-1 if LSB-first), with data 0 and out_last=1.
  - The first emitted lane after load is the first nonzero lane, still one cycle after acceptance.
- Undefined: every lane is emitted; no zero detection logic is built.

## Test plan
1. Reset, then word 0x12345678 with msb_first=1 and out_ready=1 → lanes (idx,data) = (3,12),(2,34),(1,56),(0,78); out_last only on the 4th; first lane appears one cycle after acceptance.
2. Same word with msb_first=0 → (0,78),(1,56),(2,34),(3,12); out_last on (3,12).
3. Two words 0xAABBCCDD then 0x11223344 offered continuously → 8 consecutive out_valid cycles; in_ready high only in the cycle of the last lane of the first word.
4. out_ready toggling 1,0,0,1 during a word → out_data/out_idx/out_last stable while stalled; no lane lost or duplicated.
5. reset_n pulsed low after the second lane of 0xDEADBEEF → all outputs 0 immediately; after release in_ready=1, the remaining lanes are never emitted, and the next word starts at its first lane.
6. SPLITTER_ZERO_SKIP_EN defined: 0x00AB00CD msb_first=1 → (2,AB),(0,CD,last); 0x00000000 msb_first=0 → single (3,00,last). Undefined: 0x00AB00CD → all 4 lanes.
